stream_compare_tracker: RTL

STREAM_COMPARE_TRACKER -- requirements
Module: stream_compare_tracker

---
 rtl/stream_compare_tracker_if.sv | 28 ++
 rtl/stream_compare_tracker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stream_compare_tracker_if.sv
// Sample-in / window-result-out bundle for stream_compare_tracker.
// The master modport is the environment side; the slave modport is the tracker.
interface stream_compare_tracker_if #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
);
    localparam int CNT_W = $clog2(WINDOW);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;
    logic [CNT_W-1:0] out_min_idx;
    logic [CNT_W-1:0] out_max_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx
    );
endinterface

// File: rtl/stream_compare_tracker.sv
// Windowed min/max tracker: reports the extreme samples of every WINDOW accepted samples.
// Define CMP_ABS_EN to add the abs_mode port and magnitude compare in signed mode.
//
// state | meaning
// IDLE  | waiting for the first sample of a window
// ACCUM | collecting samples 1..WINDOW-1
// EMIT  | result presented, waiting for out_ready
module stream_compare_tracker #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic signed_mode,
`ifdef CMP_ABS_EN
    input  logic abs_mode,
`endif
    stream_compare_tracker_if.slave bus
);
    localparam int CNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] min_q, max_q;
    logic [CNT_W-1:0] min_idx_q, max_idx_q;
    logic             signed_q;
    logic             accept;
    logic [WIDTH:0]   key_in, key_min, key_max;

    // Keys are unsigned WIDTH+1 ordinals so every compare is unsigned-vs-unsigned.
`ifdef CMP_ABS_EN
    logic abs_q;

    function automatic logic [WIDTH:0] cmp_key(input logic [WIDTH-1:0] x,
                                               input logic sgn, input logic ab);
        logic [WIDTH:0] k;
        if (!sgn)
            k = {1'b0, x};
        else if (ab)
            k = x[WIDTH-1] ? (~{1'b1, x} + (WIDTH+1)'(1)) : {1'b0, x};
        else
            k = {1'b0, ~x[WIDTH-1], x[WIDTH-2:0]};
        return k;
    endfunction

    assign key_in  = cmp_key(bus.in_data, signed_q, abs_q);
    assign key_min = cmp_key(min_q, signed_q, abs_q);
    assign key_max = cmp_key(max_q, signed_q, abs_q);
`else
    function automatic logic [WIDTH:0] cmp_key(input logic [WIDTH-1:0] x,
                                               input logic sgn);
        logic [WIDTH:0] k;
        if (!sgn)
            k = {1'b0, x};
        else
            k = {1'b0, ~x[WIDTH-1], x[WIDTH-2:0]};
        return k;
    endfunction

    assign key_in  = cmp_key(bus.in_data, signed_q);
    assign key_min = cmp_key(min_q, signed_q);
    assign key_max = cmp_key(max_q, signed_q);
`endif

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = ACCUM;
                ACCUM:   if (accept && cnt_q == LAST) state_d = EMIT;
                EMIT:    if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state_q != EMIT);
        bus.out_valid = (state_q == EMIT);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            signed_q  <= 1'b0;
`ifdef CMP_ABS_EN
            abs_q     <= 1'b0;
`endif
        end else if (clear) begin
            cnt_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        min_q     <= bus.in_data;
                        max_q     <= bus.in_data;
                        min_idx_q <= '0;
                        max_idx_q <= '0;
                        cnt_q     <= CNT_W'(1);
                        signed_q  <= signed_mode;
`ifdef CMP_ABS_EN
                        abs_q     <= abs_mode;
`endif
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (key_in < key_min) begin
                            min_q     <= bus.in_data;
                            min_idx_q <= cnt_q;
                        end
                        if (key_in > key_max) begin
                            max_q     <= bus.in_data;
                            max_idx_q <= cnt_q;
                        end
                        // Counter parks on the last index until the result is taken.
                        if (cnt_q != LAST)
                            cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                EMIT: begin
                    if (bus.out_ready)
                        cnt_q <= '0;
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign bus.out_min     = min_q;
    assign bus.out_max     = max_q;
    assign bus.out_min_idx = min_idx_q;
    assign bus.out_max_idx = max_idx_q;
endmodule
